// File: rtl/manchester_pkg.sv
// Constants and state encoding for the Manchester framing path, used by
// both the transmit-side inserter and the receive-side deframer.
package manchester_pkg;

  localparam logic [7:0] PREAMBLE_PATTERN = 8'hAA;
  localparam logic [7:0] START_WORD       = 8'hD5;
  localparam logic [2:0] PRE_CNT_MAX      = 3'd7;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DISCARD  = 2'd3
  } state_t;

  function automatic logic [2:0] pre_cnt_inc(input logic [2:0] cnt);
    return (cnt == PRE_CNT_MAX) ? PRE_CNT_MAX : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream register slice; a load on the same edge as a
// downstream take replaces the held beat with no bubble.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
);

  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (s_valid && s_ready) begin
      m_valid <= 1'b1;
      m_data  <= s_data;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/manchester_deframer.sv
// Hunts for the 0xAA preamble and 0xD5 start word in the decoded byte
// stream and forwards only the payload as AXI-Stream frames with tlast.
module manchester_deframer
  import manchester_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MIN_PREAMBLE  = 2,
  parameter int unsigned MAX_FRAME_LEN = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  sync_err,
  output logic                  trunc_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [2:0]  MIN_PRE = 3'(MIN_PREAMBLE);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);

  state_t      state;
  logic [2:0]  pre_cnt;
  logic [15:0] len;
  logic [15:0] len_inc;
  logic        out_ready;
  logic        accept;
  logic        load;
  logic        hit_max;
  logic        is_pre;
  logic        is_start;

  // Ready is held low throughout reset, independent of the state register.
  always_comb begin
    s_axis_tready = 1'b0;
    if (aresetn) begin
      s_axis_tready = (state == ST_DATA) ? out_ready : 1'b1;
    end
  end

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign load     = accept && (state == ST_DATA);
  assign len_inc  = len + 16'd1;
  assign hit_max  = (len_inc == MAX_LEN);
  assign is_pre   = (s_axis_tdata == PREAMBLE_PATTERN);
  assign is_start = (s_axis_tdata == START_WORD);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_HUNT;
      pre_cnt   <= '0;
      len       <= '0;
      sync_err  <= 1'b0;
      trunc_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sync_err  <= 1'b0;
      trunc_err <= 1'b0;
      if (accept) begin
        case (state)
          ST_HUNT: begin
            if (is_pre && !s_axis_tlast) begin
              state   <= ST_PREAMBLE;
              pre_cnt <= 3'd1;
            end
          end
          ST_PREAMBLE: begin
            if (is_pre && !s_axis_tlast) begin
              pre_cnt <= pre_cnt_inc(pre_cnt);
            end else if (is_start && !s_axis_tlast && pre_cnt >= MIN_PRE) begin
              state   <= ST_DATA;
              len     <= '0;
              pre_cnt <= '0;
            end else begin
              sync_err <= 1'b1;
              state    <= ST_HUNT;
              pre_cnt  <= '0;
            end
          end
          ST_DATA: begin
            len <= len_inc;
            if (s_axis_tlast) begin
              frame_cnt <= frame_cnt + 16'd1;
              state     <= ST_HUNT;
              len       <= '0;
            end else if (hit_max) begin
              frame_cnt <= frame_cnt + 16'd1;
              trunc_err <= 1'b1;
              state     <= ST_DISCARD;
              len       <= '0;
            end
          end
          ST_DISCARD: begin
            if (s_axis_tlast) begin
              state <= ST_HUNT;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  (s_axis_tdata),
    .s_last  (s_axis_tlast || hit_max),
    .s_valid (load),
    .s_ready (out_ready),
    .m_data  (m_axis_tdata),
    .m_last  (m_axis_tlast),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule
